// File: rtl/modport_apb_slave_pkg.sv
// rtl/modport_apb_slave_pkg.sv - DMA APB register map constants and address decode
package dma_apb_pkg;

  localparam logic [12:0] OFF_CTRL    = 13'h000;
  localparam logic [12:0] OFF_SRC     = 13'h004;
  localparam logic [12:0] OFF_DST     = 13'h008;
  localparam logic [12:0] OFF_SIZE    = 13'h00C;
  localparam logic [12:0] OFF_START   = 13'h010;
  localparam logic [12:0] OFF_STATUS  = 13'h014;
  localparam logic [12:0] OFF_INT_CLR = 13'h018;
  localparam logic [12:0] OFF_ID      = 13'h01C;

  localparam logic [31:0] DMA_ID = 32'hD3A0_0001;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_INT_EN_BIT = 1;
  localparam int START_REQ_BIT   = 0;
  localparam int INT_CLR_BIT     = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_REM_LSB  = 16;

  typedef enum logic [3:0] {
    REG_CTRL,
    REG_SRC,
    REG_DST,
    REG_SIZE,
    REG_START,
    REG_STATUS,
    REG_INT_CLR,
    REG_ID,
    REG_NONE
  } reg_sel_e;

  // Byte-lane bits [1:0] are ignored, so offsets are compared word-aligned.
  function automatic reg_sel_e decode(input logic [12:0] addr);
    reg_sel_e sel;
    case ({addr[12:2], 2'b00})
      OFF_CTRL:    sel = REG_CTRL;
      OFF_SRC:     sel = REG_SRC;
      OFF_DST:     sel = REG_DST;
      OFF_SIZE:    sel = REG_SIZE;
      OFF_START:   sel = REG_START;
      OFF_STATUS:  sel = REG_STATUS;
      OFF_INT_CLR: sel = REG_INT_CLR;
      OFF_ID:      sel = REG_ID;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/modport_apb_slave_if.sv
// rtl/modport_apb_slave_if.sv - APB3 bus bundle with master/slave modports
interface modport_apb_slave_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  logic              pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr, pready
  );
endinterface

// File: rtl/modport_apb_slave_counter.sv
// rtl/modport_apb_slave_counter.sv - channel countdown engine holding busy, remaining and done
module dma_xfer_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dec_en,
  input  logic             start,
  input  logic             abort,
  input  logic             clear,
  input  logic [CNT_W-1:0] size,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  always_comb begin
    busy_d = busy_q;
    rem_d  = rem_q;
    done_d = done_q;
    if (en) begin
      // Clear is applied first so a same-cycle completion still sets done.
      if (clear) done_d = 1'b0;
      if (abort) begin
        busy_d = 1'b0;
        rem_d  = '0;
      end else if (start && !busy_q) begin
        if (size != '0) begin
          busy_d = 1'b1;
          rem_d  = size;
        end else begin
          done_d = 1'b1;
        end
      end else if (busy_q && dec_en) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign remaining = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/modport_apb_slave.sv
// rtl/modport_apb_slave.sv - DMA channel APB3 register slave with transfer countdown engine
// Optional: APB_SLVERR_EN enables pslverr on unmapped, read-only and busy-start accesses.
module modport_apb_slave
  import dma_apb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pclken,
  input  logic                 scan_en,
  modport_apb_slave_if.slave   apb,
  output logic                 idle,
  output logic                 INT
);

  logic ctrl_en_q, ctrl_en_d;
  logic ctrl_int_en_q, ctrl_int_en_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  size_q, size_d;
  logic int_q, int_d;

  logic             access, wr_en;
  logic             start, abort, clear;
  logic             busy, done;
  logic [CNT_W-1:0] remaining;
  logic [DATA_W-1:0] rdata;
  reg_sel_e         sel;
  logic             unused_paddr;

  assign sel        = decode(apb.paddr);
  assign access     = apb.psel & apb.penable;
  assign apb.pready = access & pclken;
  assign wr_en      = apb.pready & apb.pwrite;
  assign unused_paddr = ^apb.paddr[1:0];

  always_comb begin
    ctrl_en_d     = ctrl_en_q;
    ctrl_int_en_d = ctrl_int_en_q;
    src_d         = src_q;
    dst_d         = dst_q;
    size_d        = size_q;
    start         = 1'b0;
    abort         = 1'b0;
    clear         = 1'b0;
    if (wr_en) begin
      case (sel)
        REG_CTRL: begin
          ctrl_en_d     = apb.pwdata[CTRL_EN_BIT];
          ctrl_int_en_d = apb.pwdata[CTRL_INT_EN_BIT];
          abort         = !apb.pwdata[CTRL_EN_BIT] && busy;
        end
        REG_SRC:     src_d  = apb.pwdata;
        REG_DST:     dst_d  = apb.pwdata;
        REG_SIZE:    size_d = apb.pwdata[CNT_W-1:0];
        REG_START:   start  = apb.pwdata[START_REQ_BIT] && ctrl_en_q;
        REG_INT_CLR: clear  = apb.pwdata[INT_CLR_BIT];
        default: ;
      endcase
    end
  end

  assign int_d = pclken ? (done & ctrl_int_en_q & !scan_en) : int_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en_q     <= 1'b0;
      ctrl_int_en_q <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      size_q        <= '0;
      int_q         <= 1'b0;
    end else begin
      ctrl_en_q     <= ctrl_en_d;
      ctrl_int_en_q <= ctrl_int_en_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      size_q        <= size_d;
      int_q         <= int_d;
    end
  end

  dma_xfer_counter #(.CNT_W(CNT_W)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (pclken),
    .dec_en    (!scan_en),
    .start     (start),
    .abort     (abort),
    .clear     (clear),
    .size      (size_q),
    .busy      (busy),
    .remaining (remaining),
    .done      (done)
  );

  always_comb begin
    rdata = '0;
    if (access) begin
      case (sel)
        REG_CTRL: begin
          rdata[CTRL_EN_BIT]     = ctrl_en_q;
          rdata[CTRL_INT_EN_BIT] = ctrl_int_en_q;
        end
        REG_SRC:  rdata = src_q;
        REG_DST:  rdata = dst_q;
        REG_SIZE: rdata[CNT_W-1:0] = size_q;
        REG_STATUS: begin
          rdata[STATUS_BUSY_BIT]              = busy;
          rdata[STATUS_DONE_BIT]              = done;
          rdata[STATUS_REM_LSB +: CNT_W]      = remaining;
        end
        REG_ID:   rdata = DMA_ID;
        default: ;
      endcase
    end
  end

  assign apb.prdata = rdata;

`ifdef APB_SLVERR_EN
  // Flagged accesses already leave register state untouched via the decode above.
  assign apb.pslverr = apb.pready & ((sel == REG_NONE) |
                       (apb.pwrite & ((sel == REG_STATUS) | (sel == REG_ID))) |
                       (apb.pwrite & (sel == REG_START) & apb.pwdata[START_REQ_BIT] & busy));
`else
  assign apb.pslverr = 1'b0;
`endif

  assign idle = !busy;
  assign INT  = int_q;

endmodule

// File: tb/tb_modport_apb_slave.sv
// tb/tb_modport_apb_slave.sv - self-checking bench for modport_apb_slave
module tb_modport_apb_slave;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pclken = 1'b1;
  logic scan_en = 1'b0;
  logic idle, INT;

  modport_apb_slave_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  modport_apb_slave #(.ADDR_W(13), .DATA_W(32), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .pclken  (pclken),
    .scan_en (scan_en),
    .apb     (bus.slave),
    .idle    (idle),
    .INT     (INT)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_clken = 1'b0;

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [12:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int  n;
    bit  got;
    rdata = '0;
    err   = 1'b0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata; pclken = 1'b1;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      pclken = (rand_clken && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      check("pready", 32'(bus.pready), 32'(pclken));
      if (bus.pready) begin
        rdata = bus.prdata;
        err   = bus.pslverr;
        got   = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!got) check("access_timeout", 32'(got), 32'd1);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; pclken = 1'b1;
  endtask

  task automatic wr(input logic [12:0] addr, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb_xfer(1'b1, addr, d, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [12:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb_xfer(1'b0, addr, 32'h0, r, e);
    check(name, r, exp);
  endtask

  task automatic count_busy(input string name, input int exp);
    int cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (idle) break;
      cnt++;
    end
    check(name, 32'(cnt), 32'(exp));
  endtask

  vec_t vecs[20];
  logic [31:0] m_src, m_dst, m_size, m_ctrl;

  initial begin
    logic [31:0] r;
    logic        e;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    vecs[0]  = '{0, 13'h01C, 32'h0,         32'hD3A0_0001, 0};
    vecs[1]  = '{1, 13'h004, 32'h1234_5678, 32'h0,         0};
    vecs[2]  = '{0, 13'h004, 32'h0,         32'h1234_5678, 0};
    vecs[3]  = '{1, 13'h008, 32'hDEAD_BEEF, 32'h0,         0};
    vecs[4]  = '{0, 13'h008, 32'h0,         32'hDEAD_BEEF, 0};
    vecs[5]  = '{1, 13'h00C, 32'hABCD_1234, 32'h0,         0};
    vecs[6]  = '{0, 13'h00C, 32'h0,         32'h0000_1234, 0};
    vecs[7]  = '{1, 13'h000, 32'hFFFF_FFFE, 32'h0,         0};
    vecs[8]  = '{0, 13'h000, 32'h0,         32'h0000_0002, 0};
    vecs[9]  = '{1, 13'h000, 32'h0,         32'h0,         0};
    vecs[10] = '{0, 13'h010, 32'h0,         32'h0,         0};
    vecs[11] = '{0, 13'h018, 32'h0,         32'h0,         0};
    vecs[12] = '{0, 13'h020, 32'h0,         32'h0,         SLV};
    vecs[13] = '{0, 13'h100, 32'h0,         32'h0,         SLV};
    vecs[14] = '{1, 13'h014, 32'hFFFF_FFFF, 32'h0,         SLV};
    vecs[15] = '{0, 13'h014, 32'h0,         32'h0,         0};
    vecs[16] = '{1, 13'h01C, 32'h0,         32'h0,         SLV};
    vecs[17] = '{0, 13'h01C, 32'h0,         32'hD3A0_0001, 0};
    vecs[18] = '{1, 13'h104, 32'hFFFF_FFFF, 32'h0,         SLV};
    vecs[19] = '{0, 13'h006, 32'h0,         32'h1234_5678, 0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_int", 32'(INT), 32'd0);
    check("rst_prdata", bus.prdata, 32'h0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    rd_chk("rst_ctrl", 13'h000, 32'h0);
    rd_chk("rst_status", 13'h014, 32'h0);

    // Register map vectors with a stuttering clock enable
    rand_clken = 1'b1;
    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e);
      if (!vecs[i].wr) check($sformatf("vec%0d_data", i), r, vecs[i].exp);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // Random register traffic against a register-array model
    m_src = 32'h1234_5678; m_dst = 32'hDEAD_BEEF; m_size = 32'h1234; m_ctrl = 32'h0;
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [31:0] d;
      logic [12:0] a;
      logic [31:0] exp;
      k = $urandom_range(0, 3);
      d = $urandom;
      a = 13'(k * 4);
      if ($urandom_range(0, 1) == 1) begin
        wr(a, d);
        case (k)
          0: m_ctrl = d & 32'h3;
          1: m_src  = d;
          2: m_dst  = d;
          default: m_size = d & 32'hFFFF;
        endcase
      end else begin
        case (k)
          0: exp = m_ctrl;
          1: exp = m_src;
          2: exp = m_dst;
          default: exp = m_size;
        endcase
        rd_chk($sformatf("rand%0d", i), a, exp);
      end
    end
    rand_clken = 1'b0;

    // SIZE=4 transfer with interrupt
    wr(13'h000, 32'h3);
    wr(13'h00C, 32'h4);
    wr(13'h010, 32'h1);
    count_busy("busy4_cycles", 4);
    rd_chk("status_done4", 13'h014, 32'h0000_0002);
    @(negedge clk);
    check("int_after4", 32'(INT), 32'd1);

    // Scan mode freezes the countdown and masks INT
    @(posedge clk); #1 scan_en = 1'b1;
    wr(13'h00C, 32'h5);
    wr(13'h010, 32'h1);
    rd_chk("scan_status_a", 13'h014, 32'h0005_0003);
    @(negedge clk);
    check("scan_int_masked", 32'(INT), 32'd0);
    repeat (3) @(posedge clk);
    rd_chk("scan_status_b", 13'h014, 32'h0005_0003);
    wr(13'h018, 32'h1);
    rd_chk("scan_status_c", 13'h014, 32'h0005_0001);
    scan_en = 1'b0;
    count_busy("busy5_cycles", 5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("int_after5", 32'(INT), 32'd1);
    rd_chk("status_done5", 13'h014, 32'h0000_0002);
    wr(13'h018, 32'h1);
    rd_chk("status_cleared", 13'h014, 32'h0);
    @(negedge clk);
    check("int_cleared", 32'(INT), 32'd0);

    // Abort by disabling while busy
    wr(13'h00C, 32'd100);
    wr(13'h010, 32'h1);
    repeat (3) @(posedge clk);
    wr(13'h000, 32'h0);
    rd_chk("abort_status", 13'h014, 32'h0);
    @(negedge clk);
    check("abort_idle", 32'(idle), 32'd1);
    check("abort_int", 32'(INT), 32'd0);

    // SIZE=0 completes instantly; abort keeps done
    wr(13'h000, 32'h3);
    wr(13'h00C, 32'h0);
    wr(13'h010, 32'h1);
    @(negedge clk);
    check("size0_idle", 32'(idle), 32'd1);
    rd_chk("size0_status", 13'h014, 32'h0000_0002);
    check("size0_int", 32'(INT), 32'd1);
    wr(13'h00C, 32'd20);
    wr(13'h010, 32'h1);
    wr(13'h000, 32'h0);
    rd_chk("abort_keeps_done", 13'h014, 32'h0000_0002);

    // START while busy is ignored (and flagged when enabled)
    wr(13'h000, 32'h1);
    wr(13'h018, 32'h1);
    wr(13'h00C, 32'd10);
    wr(13'h010, 32'h1);
    apb_xfer(1'b1, 13'h010, 32'h1, r, e);
    check("start_busy_err", 32'(e), 32'(SLV));
    apb_xfer(1'b0, 13'h014, 32'h0, r, e);
    check("start_busy_flags", r & 32'h3, 32'h1);
    wr(13'h000, 32'h0);
    wr(13'h010, 32'h1);
    rd_chk("start_en0_ignored", 13'h014, 32'h0);

    // Random transfers with random scan_en, checked against a remaining-count model
    wr(13'h000, 32'h1);
    for (int t = 0; t < 5; t++) begin
      int sz;
      int rem;
      sz = $urandom_range(1, 12);
      wr(13'h00C, 32'(sz));
      wr(13'h010, 32'h1);
      rem = sz;
      for (int k = 0; k < 200 && rem > 0; k++) begin
        @(negedge clk);
        check($sformatf("xfer%0d_busy", t), 32'(idle), 32'd0);
        scan_en = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (!scan_en) rem--;
      end
      @(negedge clk);
      scan_en = 1'b0;
      check($sformatf("xfer%0d_idle", t), 32'(idle), 32'd1);
      rd_chk($sformatf("xfer%0d_status", t), 13'h014, 32'h0000_0002);
      wr(13'h018, 32'h1);
    end

    // Asynchronous reset mid-transfer
    wr(13'h000, 32'h3);
    wr(13'h00C, 32'd50);
    wr(13'h010, 32'h1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("areset_idle", 32'(idle), 32'd1);
    check("areset_int", 32'(INT), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    rd_chk("areset_status", 13'h014, 32'h0);
    rd_chk("areset_ctrl", 13'h000, 32'h0);
    rd_chk("areset_src", 13'h004, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
